// File: rtl/mult_pipe_elastic_pkg.sv
// Shared EX-stage constants and helpers for the elastic multiplier.
// Also provides the elaboration check that the stage count divides the operand width.
package mult_pipe_elastic_pkg;

    localparam int unsigned XLEN_DEF   = 64;
    localparam int unsigned STAGES_DEF = 4;
    localparam int unsigned IR_W_DEF   = 32;
    localparam int unsigned DEST_W_DEF = 5;
    localparam int unsigned NPC_W      = 64;

    function automatic int unsigned chunk_bits(input int unsigned xlen, input int unsigned stages);
        return xlen / stages;
    endfunction

endpackage

`define MULT_PIPE_CHECK_DIV(XL, ST) \
    if (((XL) % (ST)) != 0) begin : g_div_check \
        $error("mult_pipe_elastic: XLEN must be a multiple of STAGES"); \
    end

// File: rtl/mult_pipe_elastic_if.sv
// Request/response bundle between the issue logic, the multiplier and the output arbiter.
// The slave modport is the multiplier side; master is the issue/arbiter side.
interface mult_pipe_elastic_if
    import mult_pipe_elastic_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned IR_W   = IR_W_DEF,
    parameter int unsigned DEST_W = DEST_W_DEF
);
    logic              valid_in;
    logic              ready_out;
    logic [XLEN-1:0]   mplier;
    logic [XLEN-1:0]   mcand;
    logic [IR_W-1:0]   IR_in;
    logic [NPC_W-1:0]  NPC_in;
    logic [DEST_W-1:0] dest_reg_in;
    logic              stall_in;
    logic              flush;
    logic              valid_out;
    logic [XLEN-1:0]   product;
    logic [IR_W-1:0]   IR_out;
    logic [NPC_W-1:0]  NPC_out;
    logic [DEST_W-1:0] dest_reg_out;
    logic              busy;

    modport master (
        output valid_in, mplier, mcand, IR_in, NPC_in, dest_reg_in, stall_in, flush,
        input  ready_out, valid_out, product, IR_out, NPC_out, dest_reg_out, busy
    );

    modport slave (
        input  valid_in, mplier, mcand, IR_in, NPC_in, dest_reg_in, stall_in, flush,
        output ready_out, valid_out, product, IR_out, NPC_out, dest_reg_out, busy
    );
endinterface

// File: rtl/mult_pipe_elastic_stage.sv
// One multiplier stage: adds CHUNK partial product bits and passes shifted operands on.
// Loads everything when load_i is high, otherwise holds; flush clears only the valid bit.
module mult_pipe_elastic_stage
    import mult_pipe_elastic_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned CHUNK  = XLEN_DEF / STAGES_DEF,
    parameter int unsigned IR_W   = IR_W_DEF,
    parameter int unsigned DEST_W = DEST_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              v_i,
    input  logic [XLEN-1:0]   prod_i,
    input  logic [XLEN-1:0]   mpl_i,
    input  logic [XLEN-1:0]   mcd_i,
    input  logic [IR_W-1:0]   ir_i,
    input  logic [NPC_W-1:0]  npc_i,
    input  logic [DEST_W-1:0] dest_i,
    output logic              v_o,
    output logic [XLEN-1:0]   prod_o,
    output logic [XLEN-1:0]   mpl_o,
    output logic [XLEN-1:0]   mcd_o,
    output logic [IR_W-1:0]   ir_o,
    output logic [NPC_W-1:0]  npc_o,
    output logic [DEST_W-1:0] dest_o
);
    logic              v_q;
    logic [XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]   mpl_q, mpl_d;
    logic [XLEN-1:0]   mcd_q, mcd_d;
    logic [IR_W-1:0]   ir_q;
    logic [NPC_W-1:0]  npc_q;
    logic [DEST_W-1:0] dest_q;

    // Only the low XLEN bits of the running sum are ever needed.
    assign prod_d = prod_i + XLEN'(mpl_i[CHUNK-1:0]) * mcd_i;
    assign mpl_d  = mpl_i >> CHUNK;
    assign mcd_d  = mcd_i << CHUNK;

    always_ff @(posedge clock) begin
        if (reset) begin
            v_q    <= 1'b0;
            prod_q <= '0;
            mpl_q  <= '0;
            mcd_q  <= '0;
            ir_q   <= '0;
            npc_q  <= '0;
            dest_q <= '0;
        end else begin
            if (flush_i) begin
                v_q <= 1'b0;
            end else if (load_i) begin
                v_q <= v_i;
            end
            if (load_i) begin
                prod_q <= prod_d;
                mpl_q  <= mpl_d;
                mcd_q  <= mcd_d;
                ir_q   <= ir_i;
                npc_q  <= npc_i;
                dest_q <= dest_i;
            end
        end
    end

    assign v_o    = v_q;
    assign prod_o = prod_q;
    assign mpl_o  = mpl_q;
    assign mcd_o  = mcd_q;
    assign ir_o   = ir_q;
    assign npc_o  = npc_q;
    assign dest_o = dest_q;
endmodule

// File: rtl/mult_pipe_elastic.sv
// Elastic STAGES-deep low-half multiplier, STAGES cycles latency, 1 result/cycle unstalled.
// stall_in holds the last stage; upstream stages keep filling bubbles until the pipe is full.
module mult_pipe_elastic
    import mult_pipe_elastic_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned STAGES = STAGES_DEF,
    parameter int unsigned IR_W   = IR_W_DEF,
    parameter int unsigned DEST_W = DEST_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    mult_pipe_elastic_if.slave  bus
);
    localparam int unsigned CHUNK = chunk_bits(XLEN, STAGES);

    `MULT_PIPE_CHECK_DIV(XLEN, STAGES)

    // Index 0 is the incoming request; index k+1 is the output of stage k.
    logic [STAGES:0]   v_a;
    logic [XLEN-1:0]   prod_a [STAGES+1];
    logic [XLEN-1:0]   mpl_a  [STAGES+1];
    logic [XLEN-1:0]   mcd_a  [STAGES+1];
    logic [IR_W-1:0]   ir_a   [STAGES+1];
    logic [NPC_W-1:0]  npc_a  [STAGES+1];
    logic [DEST_W-1:0] dest_a [STAGES+1];
    logic [STAGES-1:0] adv;

    assign v_a[0]    = bus.valid_in;
    assign prod_a[0] = '0;
    assign mpl_a[0]  = bus.mplier;
    assign mcd_a[0]  = bus.mcand;
    assign ir_a[0]   = bus.IR_in;
    assign npc_a[0]  = bus.NPC_in;
    assign dest_a[0] = bus.dest_reg_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // A stage may advance unless it and every stage below it are full and the output is stalled.
        assign adv[k] = !(&v_a[STAGES:k+1]) || !bus.stall_in;

        mult_pipe_elastic_stage #(
            .XLEN   (XLEN),
            .CHUNK  (CHUNK),
            .IR_W   (IR_W),
            .DEST_W (DEST_W)
        ) u_stage (
            .clock   (clock),
            .reset   (reset),
            .flush_i (bus.flush),
            .load_i  (adv[k]),
            .v_i     (v_a[k]),
            .prod_i  (prod_a[k]),
            .mpl_i   (mpl_a[k]),
            .mcd_i   (mcd_a[k]),
            .ir_i    (ir_a[k]),
            .npc_i   (npc_a[k]),
            .dest_i  (dest_a[k]),
            .v_o     (v_a[k+1]),
            .prod_o  (prod_a[k+1]),
            .mpl_o   (mpl_a[k+1]),
            .mcd_o   (mcd_a[k+1]),
            .ir_o    (ir_a[k+1]),
            .npc_o   (npc_a[k+1]),
            .dest_o  (dest_a[k+1])
        );
    end

    assign bus.ready_out    = adv[0];
    assign bus.valid_out    = v_a[STAGES];
    assign bus.product      = prod_a[STAGES];
    assign bus.IR_out       = ir_a[STAGES];
    assign bus.NPC_out      = npc_a[STAGES];
    assign bus.dest_reg_out = dest_a[STAGES];
    assign bus.busy         = |v_a[STAGES:1];
endmodule

// File: tb/tb_mult_pipe_elastic.sv
// Bench for mult_pipe_elastic: scoreboarded STAGES=4 instance plus STAGES=1/2/8 instances for width wrap.
module tb_mult_pipe_elastic;
    typedef struct {
        logic [63:0] prod;
        logic [31:0] ir;
        logic [63:0] npc;
        logic [4:0]  dest;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mult_pipe_elastic_if #(.XLEN(64), .IR_W(32), .DEST_W(5)) bus ();
    mult_pipe_elastic_if #(.XLEN(64), .IR_W(32), .DEST_W(5)) b1 ();
    mult_pipe_elastic_if #(.XLEN(64), .IR_W(32), .DEST_W(5)) b2 ();
    mult_pipe_elastic_if #(.XLEN(64), .IR_W(32), .DEST_W(5)) b8 ();

    mult_pipe_elastic #(.XLEN(64), .STAGES(4), .IR_W(32), .DEST_W(5)) dut  (.clock(clock), .reset(reset), .bus(bus));
    mult_pipe_elastic #(.XLEN(64), .STAGES(1), .IR_W(32), .DEST_W(5)) u_s1 (.clock(clock), .reset(reset), .bus(b1));
    mult_pipe_elastic #(.XLEN(64), .STAGES(2), .IR_W(32), .DEST_W(5)) u_s2 (.clock(clock), .reset(reset), .bus(b2));
    mult_pipe_elastic #(.XLEN(64), .STAGES(8), .IR_W(32), .DEST_W(5)) u_s8 (.clock(clock), .reset(reset), .bus(b8));

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t held;
    bit   held_vld = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   run_len = 0;
    int   max_run = 0;
    int   ready_low_cnt = 0;
    bit   rnd_done = 1'b0;
    logic [63:0] all1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // Scoreboard consumer: a result leaves the DUT on any cycle with valid_out and no stall.
    always @(negedge clock) begin
        if (reset || bus.flush) begin
            held_vld = 1'b0;
            run_len  = 0;
        end else begin
            if (held_vld) begin
                check("hold_valid", 64'(bus.valid_out), 64'd1);
                check("hold_product", bus.product, held.prod);
                check("hold_ir", 64'(bus.IR_out), 64'(held.ir));
                check("hold_npc", bus.NPC_out, held.npc);
                check("hold_dest", 64'(bus.dest_reg_out), 64'(held.dest));
            end
            if (bus.valid_out && !bus.stall_in) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%0h expected=none", bus.product);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("out_product", bus.product, mon_e.prod);
                    check("out_ir", 64'(bus.IR_out), 64'(mon_e.ir));
                    check("out_npc", bus.NPC_out, mon_e.npc);
                    check("out_dest", 64'(bus.dest_reg_out), 64'(mon_e.dest));
                end
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            held_vld  = bus.valid_out && bus.stall_in;
            held.prod = bus.product;
            held.ir   = bus.IR_out;
            held.npc  = bus.NPC_out;
            held.dest = bus.dest_reg_out;
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [31:0] ir,
                        input logic [63:0] npc, input logic [4:0] dest);
        exp_t e;
        bit   done = 1'b0;
        bus.valid_in = 1'b1; bus.mplier = a; bus.mcand = b;
        bus.IR_in = ir; bus.NPC_in = npc; bus.dest_reg_in = dest;
        for (int w = 0; w < 60 && !done; w++) begin
            @(negedge clock);
            if (bus.ready_out) begin
                e.prod = a * b;
                e.ir = ir; e.npc = npc; e.dest = dest;
                sb_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clock); #1;
        end
        if (!done) fail_timeout("send_accept");
        bus.valid_in = 1'b0;
    endtask

    task automatic send_rand(input logic [63:0] a, input logic [63:0] b);
        send(a, b, $urandom, {$urandom, $urandom}, 5'($urandom_range(0, 31)));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic drain();
        int w = 0;
        while (bus.busy && w < 200) begin @(posedge clock); #1; w++; end
        if (bus.busy) fail_timeout("drain");
        check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic measure_latency(input string name, input int exp_lat);
        int n = 1;
        while (!bus.valid_out && n < 50) begin @(posedge clock); #1; n++; end
        check(name, 64'(n), 64'(exp_lat));
    endtask

    task automatic stall_on_first(input int hold);
        int w = 0;
        while (!bus.valid_out && w < 60) begin @(posedge clock); #1; w++; end
        if (!bus.valid_out) fail_timeout("stall_wait");
        bus.stall_in = 1'b1;
        repeat (hold) begin
            @(negedge clock);
            if (!bus.ready_out) ready_low_cnt++;
            @(posedge clock); #1;
        end
        bus.stall_in = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat1, lat2, lat8;
        logic [63:0] p1, p2, p8;
        all1 = '1;
        bus.valid_in = 0; bus.mplier = 0; bus.mcand = 0; bus.IR_in = 0; bus.NPC_in = 0;
        bus.dest_reg_in = 0; bus.stall_in = 0; bus.flush = 0;
        b1.valid_in = 0; b1.mplier = 0; b1.mcand = 0; b1.IR_in = 0; b1.NPC_in = 0;
        b1.dest_reg_in = 0; b1.stall_in = 0; b1.flush = 0;
        b2.valid_in = 0; b2.mplier = 0; b2.mcand = 0; b2.IR_in = 0; b2.NPC_in = 0;
        b2.dest_reg_in = 0; b2.stall_in = 0; b2.flush = 0;
        b8.valid_in = 0; b8.mplier = 0; b8.mcand = 0; b8.IR_in = 0; b8.NPC_in = 0;
        b8.dest_reg_in = 0; b8.stall_in = 0; b8.flush = 0;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_valid_out", 64'(bus.valid_out), 64'd0);
        check("rst_product", bus.product, 64'd0);
        check("rst_ir", 64'(bus.IR_out), 64'd0);
        check("rst_npc", bus.NPC_out, 64'd0);
        check("rst_dest", 64'(bus.dest_reg_out), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_ready", 64'(bus.ready_out), 64'd1);
        check("rst_s1_valid", 64'(b1.valid_out), 64'd0);
        check("rst_s8_busy", 64'(b8.busy), 64'd0);
        check("rst_s2_product", b2.product, 64'd0);

        // Single operation and its latency
        send(64'd3, 64'd5, 32'h12345678, 64'h0000_1000_0000_0040, 5'd7);
        measure_latency("single_latency", 4);
        check("single_product", bus.product, 64'd15);
        check("single_ir", 64'(bus.IR_out), 64'h12345678);
        check("single_dest", 64'(bus.dest_reg_out), 64'd7);
        drain();

        // Back-to-back stream
        max_run = 0;
        for (int i = 0; i < 8; i++) send_rand(64'(i), 64'(i + 1));
        drain();
        check("b2b_consecutive", 64'(max_run), 64'd8);

        // Backpressure with a full pipe
        max_run = 0; ready_low_cnt = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_rand({$urandom, $urandom}, {$urandom, $urandom});
            end
            stall_on_first(5);
        join
        drain();
        check("bp_ready_dropped", 64'(ready_low_cnt > 0), 64'd1);
        check("bp_consecutive", 64'(max_run), 64'd6);

        // Bubble collapse behind a stalled result
        max_run = 0; ready_low_cnt = 0;
        fork
            begin
                send_rand(64'd11, 64'd13);
                idle(3);
                send_rand(64'd17, 64'd19);
            end
            stall_on_first(6);
        join
        drain();
        check("bubble_ready_high", 64'(ready_low_cnt), 64'd0);
        check("bubble_adjacent", 64'(max_run), 64'd2);

        // Flush with three ops in flight plus a fourth presented
        for (int i = 0; i < 3; i++) send_rand({$urandom, $urandom}, 64'(i + 2));
        bus.valid_in = 1'b1; bus.mplier = 64'd9; bus.mcand = 64'd9; bus.flush = 1'b1;
        @(negedge clock);
        sb_q.delete();
        @(posedge clock); #1;
        bus.flush = 1'b0; bus.valid_in = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_valid_out", 64'(bus.valid_out), 64'd0);
        idle(8);
        drain();

        // Width wrap on every depth
        send_rand(all1, all1);
        measure_latency("wrap_lat_s4", 4);
        check("wrap_prod_s4", bus.product, 64'd1);
        drain();
        b1.mplier = all1; b1.mcand = all1; b1.valid_in = 1'b1;
        b2.mplier = all1; b2.mcand = all1; b2.valid_in = 1'b1;
        b8.mplier = all1; b8.mcand = all1; b8.valid_in = 1'b1;
        @(negedge clock);
        check("wrap_rdy_s1", 64'(b1.ready_out), 64'd1);
        check("wrap_rdy_s2", 64'(b2.ready_out), 64'd1);
        check("wrap_rdy_s8", 64'(b8.ready_out), 64'd1);
        @(posedge clock); #1;
        b1.valid_in = 1'b0; b2.valid_in = 1'b0; b8.valid_in = 1'b0;
        lat1 = 0; lat2 = 0; lat8 = 0; p1 = '0; p2 = '0; p8 = '0;
        for (int n = 1; n <= 20; n++) begin
            if (b1.valid_out && lat1 == 0) begin lat1 = n; p1 = b1.product; end
            if (b2.valid_out && lat2 == 0) begin lat2 = n; p2 = b2.product; end
            if (b8.valid_out && lat8 == 0) begin lat8 = n; p8 = b8.product; end
            @(posedge clock); #1;
        end
        check("wrap_lat_s1", 64'(lat1), 64'd1);
        check("wrap_lat_s2", 64'(lat2), 64'd2);
        check("wrap_lat_s8", 64'(lat8), 64'd8);
        check("wrap_prod_s1", p1, 64'd1);
        check("wrap_prod_s2", p2, 64'd1);
        check("wrap_prod_s8", p8, 64'd1);

        // Random operands under random output stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send_rand({$urandom, $urandom}, ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 255)));
                    idle($urandom_range(0, 2));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clock); #1;
                    bus.stall_in = ($urandom_range(0, 2) == 0);
                end
                bus.stall_in = 1'b0;
            end
        join
        drain();

        // Reset in the middle of work
        send_rand(64'd21, 64'd23);
        send_rand(64'd25, 64'd27);
        reset = 1'b1;
        @(negedge clock);
        sb_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst_valid_out", 64'(bus.valid_out), 64'd0);
        check("midrst_product", bus.product, 64'd0);
        check("midrst_ir", 64'(bus.IR_out), 64'd0);
        check("midrst_npc", bus.NPC_out, 64'd0);
        check("midrst_dest", 64'(bus.dest_reg_out), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_ready", 64'(bus.ready_out), 64'd1);
        idle(8);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
